// File: rtl/gb_timer_pkg.sv
// Shared DMG timer definitions: register map, IF bit position and overflow sequencing states.
// Imported by the timer and available to the CPU and memory-map logic.
package gb_timer_pkg;

   localparam logic [15:0] ADDR_DIV  = 16'hFF04;
   localparam logic [15:0] ADDR_TIMA = 16'hFF05;
   localparam logic [15:0] ADDR_TMA  = 16'hFF06;
   localparam logic [15:0] ADDR_TAC  = 16'hFF07;

   localparam int IF_TIMER_BIT = 2;

   // RUN: normal counting; DELAY: TIMA just wrapped and reads 0; RELOAD: TMA copied, irq asserted
   typedef enum logic [1:0] {
      TS_RUN    = 2'd0,
      TS_DELAY  = 2'd1,
      TS_RELOAD = 2'd2
   } timer_state_t;

   function automatic logic [3:0] tac_bit_index(input logic [1:0] sel);
      case (sel)
         2'b00:   return 4'd9;
         2'b01:   return 4'd3;
         2'b10:   return 4'd5;
         default: return 4'd7;
      endcase
   endfunction

endpackage

// File: rtl/gb_timer.sv
// DMG timer: DIV/TIMA/TMA/TAC with falling-edge tick detection, including the
// DIV/TAC write glitch and the one-cycle delayed TMA reload with its write races.
module gb_timer
   import gb_timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  data_i,
   input  logic [15:0] addr,
   input  logic        wren,
   output logic [7:0]  data_o,
   output logic        irq_timer
);

   logic [15:0]  counter, counter_next;
   logic [7:0]   tima, tima_next;
   logic [7:0]   tma, tma_next;
   logic [2:0]   tac, tac_next;
   logic         tick_q, tick_now, tick_fall;
   logic         irq_q, irq_next;
   timer_state_t state, state_next;
   logic         wr_div, wr_tima, wr_tma, wr_tac;

   assign wr_div  = wren && (addr == ADDR_DIV);
   assign wr_tima = wren && (addr == ADDR_TIMA);
   assign wr_tma  = wren && (addr == ADDR_TMA);
   assign wr_tac  = wren && (addr == ADDR_TAC);

   // The tick is sampled live from the counter, so clearing DIV or disabling TAC can fake a falling edge
   assign tick_now  = tac[2] & counter[tac_bit_index(tac[1:0])];
   assign tick_fall = tick_q & ~tick_now;

   assign irq_timer = irq_q;

   always_comb begin
      data_o = 8'hFF;
      case (addr)
         ADDR_DIV:  data_o = counter[15:8];
         ADDR_TIMA: data_o = tima;
         ADDR_TMA:  data_o = tma;
         ADDR_TAC:  data_o = {5'b11111, tac};
         default:   data_o = 8'hFF;
      endcase
   end

   always_comb begin
      counter_next = wr_div ? 16'h0000 : counter + 16'd4;
      tma_next     = wr_tma ? data_i : tma;
      tac_next     = wr_tac ? data_i[2:0] : tac;
      tima_next    = tima;
      state_next   = TS_RUN;
      irq_next     = 1'b0;

      case (state)
         TS_DELAY: begin
            // A CPU write here cancels the pending reload and its interrupt
            if (wr_tima) begin
               tima_next = data_i;
            end else begin
               tima_next  = tma_next;
               irq_next   = 1'b1;
               state_next = TS_RELOAD;
            end
         end
         TS_RELOAD: begin
            if (wr_tma) begin
               tima_next = data_i;
            end
         end
         default: begin
            if (wr_tima) begin
               tima_next = data_i;
            end else if (tick_fall) begin
               tima_next = tima + 8'd1;
               if (tima == 8'hFF) begin
                  state_next = TS_DELAY;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         counter <= 16'h0000;
         tima    <= 8'h00;
         tma     <= 8'h00;
         tac     <= 3'b000;
         tick_q  <= 1'b0;
         irq_q   <= 1'b0;
         state   <= TS_RUN;
      end else begin
         counter <= counter_next;
         tima    <= tima_next;
         tma     <= tma_next;
         tac     <= tac_next;
         tick_q  <= tick_now;
         irq_q   <= irq_next;
         state   <= state_next;
      end
   end

endmodule

// File: tb/tb_gb_timer.sv
// Self-checking bench for gb_timer: directed cycle table, hand-written corner
// sequences and a randomized run against a behavioural reference model.
module tb_gb_timer;

   logic        clk;
   logic        reset;
   logic [7:0]  data_i;
   logic [15:0] addr;
   logic        wren;
   logic [7:0]  data_o;
   logic        irq_timer;

   int compared;
   int mismatched;

   gb_timer dut (
      .clk       (clk),
      .reset     (reset),
      .data_i    (data_i),
      .addr      (addr),
      .wren      (wren),
      .data_o    (data_o),
      .irq_timer (irq_timer)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: counter as an integer, overflow tracked as an age (0 none, 1 delay, 2 reload)
   int unsigned m_cnt;
   int          m_tima, m_tma, m_tac, m_phase;
   bit          m_prev, m_irq;
   int          tap_of[4] = '{9, 3, 5, 7};

   task automatic model_reset();
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_phase = 0;
      m_prev = 1'b0; m_irq = 1'b0;
   endtask

   function automatic int model_read(input logic [15:0] a);
      case (a)
         16'hFF04: return int'((m_cnt / 256) % 256);
         16'hFF05: return m_tima;
         16'hFF06: return m_tma;
         16'hFF07: return 248 + m_tac;
         default:  return 255;
      endcase
   endfunction

   task automatic model_step(input bit we, input logic [15:0] a, input logic [7:0] d);
      bit cur;
      bit fell;
      int new_tma;
      cur     = (m_tac >= 4) && (((m_cnt >> tap_of[m_tac % 4]) % 2) == 1);
      fell    = m_prev && !cur;
      new_tma = (we && a == 16'hFF06) ? int'(d) : m_tma;
      m_irq   = 1'b0;
      if (m_phase == 1) begin
         if (we && a == 16'hFF05) begin
            m_tima  = d;
            m_phase = 0;
         end else begin
            m_tima  = new_tma;
            m_irq   = 1'b1;
            m_phase = 2;
         end
      end else if (m_phase == 2) begin
         if (we && a == 16'hFF06) m_tima = d;
         m_phase = 0;
      end else begin
         if (we && a == 16'hFF05) m_tima = d;
         else if (fell) begin
            m_tima = m_tima + 1;
            if (m_tima == 256) begin
               m_tima  = 0;
               m_phase = 1;
            end
         end
      end
      m_tma = new_tma;
      if (we && a == 16'hFF07) m_tac = d % 8;
      m_cnt  = (we && a == 16'hFF04) ? 0 : (m_cnt + 4) % 65536;
      m_prev = cur;
   endtask

   task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      wren = 1'b0; addr = 16'h0000; data_i = 8'h00;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic cycle(input bit we, input logic [15:0] a, input logic [7:0] d);
      wren = we; addr = a; data_i = d;
      @(posedge clk);
      model_step(we, a, d);
      #1;
      wren = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
      wren = 1'b0; addr = a;
      #1;
      check_output(name, data_o, exp);
   endtask

   typedef struct {
      logic        we;
      logic [15:0] a;
      logic [7:0]  d;
      logic [7:0]  exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[33];

   // One row per clock: outputs checked mid-cycle, then the write lands on the closing edge
   task automatic apply_stimulus();
      for (int i = 0; i < 33; i++) begin
         wren = vecs[i].we; addr = vecs[i].a; data_i = vecs[i].d;
         #2;
         check_output($sformatf("vec%0d_rd", i), data_o, vecs[i].exp_rd);
         check_output($sformatf("vec%0d_irq", i), {7'b0, irq_timer}, {7'b0, vecs[i].exp_irq});
         @(posedge clk);
         model_step(vecs[i].we, vecs[i].a, vecs[i].d);
         #1;
      end
      wren = 1'b0;
   endtask

   logic [15:0] addr_pool[10] = '{16'hFF04, 16'hFF05, 16'hFF05, 16'hFF06, 16'hFF07,
                                  16'hFF07, 16'hFF08, 16'hFF03, 16'h0000, 16'hFF05};

   initial begin
      bit          found;
      bit          we;
      logic [15:0] a;
      logic [7:0]  d;

      compared = 0; mismatched = 0;
      wren = 1'b0; addr = 16'h0000; data_i = 8'h00; reset = 1'b0;

      vecs[0]  = '{1'b0, 16'hFF04, 8'h00, 8'h00, 1'b0};
      vecs[1]  = '{1'b1, 16'hFF07, 8'h05, 8'hF8, 1'b0};
      vecs[2]  = '{1'b1, 16'hFF06, 8'hFE, 8'h00, 1'b0};
      vecs[3]  = '{1'b1, 16'hFF05, 8'hFF, 8'h00, 1'b0};
      vecs[4]  = '{1'b0, 16'hFF05, 8'h00, 8'hFF, 1'b0};
      vecs[5]  = '{1'b0, 16'hFF05, 8'h00, 8'h00, 1'b0};
      vecs[6]  = '{1'b0, 16'hFF05, 8'h00, 8'hFE, 1'b1};
      vecs[7]  = '{1'b0, 16'hFF05, 8'h00, 8'hFE, 1'b0};
      vecs[8]  = '{1'b0, 16'hFF05, 8'h00, 8'hFE, 1'b0};
      vecs[9]  = '{1'b0, 16'hFF05, 8'h00, 8'hFF, 1'b0};
      vecs[10] = '{1'b0, 16'hFF05, 8'h00, 8'hFF, 1'b0};
      vecs[11] = '{1'b0, 16'hFF05, 8'h00, 8'hFF, 1'b0};
      vecs[12] = '{1'b0, 16'hFF05, 8'h00, 8'hFF, 1'b0};
      vecs[13] = '{1'b1, 16'hFF05, 8'h10, 8'h00, 1'b0};
      vecs[14] = '{1'b0, 16'hFF05, 8'h00, 8'h10, 1'b0};
      vecs[15] = '{1'b0, 16'hFF05, 8'h00, 8'h10, 1'b0};
      vecs[16] = '{1'b0, 16'hFF05, 8'h00, 8'h10, 1'b0};
      vecs[17] = '{1'b1, 16'hFF05, 8'hFF, 8'h11, 1'b0};
      vecs[18] = '{1'b0, 16'hFF05, 8'h00, 8'hFF, 1'b0};
      vecs[19] = '{1'b0, 16'hFF05, 8'h00, 8'hFF, 1'b0};
      vecs[20] = '{1'b0, 16'hFF05, 8'h00, 8'hFF, 1'b0};
      vecs[21] = '{1'b0, 16'hFF05, 8'h00, 8'h00, 1'b0};
      vecs[22] = '{1'b1, 16'hFF05, 8'h77, 8'hFE, 1'b1};
      vecs[23] = '{1'b1, 16'hFF05, 8'hFF, 8'hFE, 1'b0};
      vecs[24] = '{1'b0, 16'hFF05, 8'h00, 8'hFF, 1'b0};
      vecs[25] = '{1'b0, 16'hFF05, 8'h00, 8'h00, 1'b0};
      vecs[26] = '{1'b1, 16'hFF06, 8'h33, 8'hFE, 1'b1};
      vecs[27] = '{1'b0, 16'hFF05, 8'h00, 8'h33, 1'b0};
      vecs[28] = '{1'b0, 16'hFF06, 8'h00, 8'h33, 1'b0};
      vecs[29] = '{1'b0, 16'hFF05, 8'h00, 8'h34, 1'b0};
      vecs[30] = '{1'b1, 16'hFF04, 8'h55, 8'h00, 1'b0};
      vecs[31] = '{1'b0, 16'hFF05, 8'h00, 8'h34, 1'b0};
      vecs[32] = '{1'b0, 16'hFF05, 8'h00, 8'h35, 1'b0};

      // Reset values and DIV rate / clear
      do_reset();
      read_check("rst_div", 16'hFF04, 8'h00);
      read_check("rst_tac", 16'hFF07, 8'hF8);
      read_check("rst_tima", 16'hFF05, 8'h00);
      check_output("rst_irq", {7'b0, irq_timer}, 8'h00);
      repeat (256) cycle(1'b0, 16'h0000, 8'h00);
      read_check("div_256", 16'hFF04, 8'h04);
      cycle(1'b1, 16'hFF04, 8'h55);
      read_check("div_clear", 16'hFF04, 8'h00);

      // Cycle-exact overflow, reload races and DIV glitch
      do_reset();
      apply_stimulus();

      // Tick rate at the fastest setting
      do_reset();
      cycle(1'b1, 16'hFF07, 8'h05);
      cycle(1'b1, 16'hFF05, 8'h00);
      repeat (15) cycle(1'b0, 16'h0000, 8'h00);
      read_check("rate_16", 16'hFF05, 8'h04);

      // Disabled timer, read-back, unmapped writes
      do_reset();
      cycle(1'b1, 16'hFF07, 8'hF9);
      cycle(1'b1, 16'hFF05, 8'h5A);
      cycle(1'b1, 16'hFF08, 8'h12);
      cycle(1'b1, 16'hFF03, 8'h34);
      repeat (1000) cycle(1'b0, 16'h0000, 8'h00);
      read_check("dis_tima", 16'hFF05, 8'h5A);
      read_check("dis_tac", 16'hFF07, 8'hF9);
      read_check("unmapped", 16'hFF08, 8'hFF);
      read_check("dis_tma", 16'hFF06, 8'h00);

      // Reset during the overflow delay discards the reload
      do_reset();
      cycle(1'b1, 16'hFF07, 8'h05);
      cycle(1'b1, 16'hFF06, 8'hAB);
      cycle(1'b1, 16'hFF05, 8'hFF);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         addr = 16'hFF05;
         #1;
         if (data_o == 8'h00) found = 1'b1;
         else cycle(1'b0, 16'hFF05, 8'h00);
      end
      compared++;
      if (!found) begin
         mismatched++;
         $display("[TB] FAIL ovf_wait: got no overflow, expected one within 40 cycles");
      end
      reset = 1'b0;
      model_reset();
      read_check("mid_rst_tima", 16'hFF05, 8'h00);
      read_check("mid_rst_tma", 16'hFF06, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 16'hFF05, 8'h00);
         check_output("post_rst_irq", {7'b0, irq_timer}, 8'h00);
      end
      read_check("post_rst_tima", 16'hFF05, 8'h00);

      // Randomized run against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         we = ($urandom_range(0, 5) == 0);
         a  = addr_pool[$urandom_range(0, 9)];
         d  = 8'($urandom);
         if (a == 16'hFF05 && $urandom_range(0, 1) == 1) d = 8'hFC + 8'($urandom_range(0, 3));
         wren = we; addr = a; data_i = d;
         #2;
         check_output("rnd_rd", data_o, 8'(model_read(a)));
         check_output("rnd_irq", {7'b0, irq_timer}, {7'b0, m_irq});
         @(posedge clk);
         model_step(we, a, d);
         #1;
      end
      wren = 1'b0;

      // Asynchronous reset mid-count takes effect without a clock edge
      #2;
      reset = 1'b0;
      #1;
      check_output("async_irq", {7'b0, irq_timer}, 8'h00);
      read_check("async_div", 16'hFF04, 8'h00);
      read_check("async_tac", 16'hFF07, 8'hF8);
      read_check("async_tima", 16'hFF05, 8'h00);
      read_check("async_tma", 16'hFF06, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/gb_timer.md
GB_TIMER -- requirements
Module: gb_timer

Interface
REQ-001 Parameters: none; all timing fixed by the DMG timer definition.
REQ-002 clk  input  1  system clock; one rising edge = one M-cycle = 4 T-cycles.
REQ-003 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-004 data_i  input  8  write data from the CPU data bus.
REQ-005 addr  input  16  CPU address bus.
REQ-006 wren  input  1  write strobe; a write occurs at the rising clk edge when wren=1 and addr selects a timer register.
REQ-007 data_o  output  8  combinational read data for the addressed timer register.
REQ-008 irq_timer  output  1  registered one-clk pulse requesting the timer interrupt (IF bit 2).

Function
REQ-009 Registers SHALL be DIV 0xFF04, TIMA 0xFF05, TMA 0xFF06 and TAC 0xFF07.
REQ-010 An internal 16-bit system counter SHALL advance by 4 every clk.
REQ-011 DIV reads SHALL return counter[15:8].
REQ-012 Any write to DIV SHALL clear the whole 16-bit counter, regardless of data_i.
REQ-013 data_o for DIV/TIMA/TMA SHALL return the register value.
REQ-014 data_o for TAC SHALL return {5'b11111, TAC[2:0]}.
REQ-015 data_o for any other address SHALL be 0xFF.
REQ-016 TAC[2] SHALL be the timer enable.
REQ-017 TAC[1:0] SHALL select the counter bit: 00->bit 9, 01->bit 3, 10->bit 5, 11->bit 7.
REQ-018 The tick signal SHALL be (selected counter bit AND TAC[2]), registered each clk.
REQ-019 TIMA SHALL increment by 1 on each 1->0 transition of the tick signal.
REQ-020 Consequence of REQ-018/019: DIV writes and TAC writes that drop the tick signal from 1 to 0 SHALL also increment TIMA (DMG glitch behaviour).
REQ-021 Overflow: TIMA increment from 0xFF SHALL wrap to 0x00 and set a pending-reload flag.
REQ-022 Reload cycle (the clk after overflow): TIMA <= TMA, irq_timer=1 for exactly that one clk, pending flag cleared.
REQ-023 TIMA SHALL read 0x00 during the one-clk delay between overflow and reload.
REQ-024 A CPU write to TIMA during the delay cycle SHALL take the written value, cancel the reload and suppress irq_timer.
REQ-025 A CPU write to TIMA in the reload cycle SHALL be ignored; TMA wins.
REQ-026 A CPU write to TMA in the reload cycle SHALL update TMA, and TIMA SHALL load the new value.
REQ-027 A CPU write to TIMA coinciding with a tick increment (not delay or reload) SHALL win; the increment is dropped.
REQ-028 TAC writes SHALL store only data_i[2:0].
REQ-029 Writes to addresses outside 0xFF04-0xFF07 SHALL have no effect.

Reset
REQ-030 While reset=0, asynchronously: counter=0, TIMA=0x00, TMA=0x00, TAC=0, pending flag=0, tick register=0, irq_timer=0.
REQ-031 Output values in reset: DIV reads 0x00 and TAC reads 0xF8.
REQ-032 Reset asserted mid-overflow SHALL discard the pending reload and emit no irq pulse.

Structure
REQ-033 Register address constants (0xFF04-0xFF07) and the IF timer bit index (2) SHALL live in the shared gb package, for use by the CPU and memory map.
REQ-034 Single flat module; no sub-module is required.

Verification
REQ-035 DIV: release reset, idle 256 clk -> DIV reads 0x04; write DIV with 0x55 -> next read 0x00.
REQ-036 Tick rate: TAC=0x05, TIMA=0x00 -> TIMA increments every 4 clk (reads 0x04 after 16 clk).
REQ-037 Overflow and reload: TMA=0xFE, TIMA=0xFF, TAC=0x05 -> on overflow TIMA reads 0x00 for one clk, then 0xFE with a single one-clk irq_timer pulse.
REQ-038 Reload cancel: TIMA write of 0x10 during the delay cycle -> TIMA=0x10, no irq_timer pulse; a TMA write of 0x33 in the reload cycle -> TIMA=0x33.
REQ-039 Disabled and read-back: TAC=0x01 -> TIMA stays constant for 1000 clk; TAC reads 0xF9; unmapped address 0xFF08 reads 0xFF.
REQ-040 Glitch and reset: with TAC=0x05 and counter bit 3 high, a DIV write -> TIMA +1; reset=0 asserted mid-count -> all outputs at reset values immediately, without waiting for clk.
